prog_bool_unit: RTL and testbench

- Parameterised, pipelined programmable boolean function unit.
- Evaluates N_CH independent boolean functions of one N_IN-bit input vector, each defined by a truth table held in registers.
- Streams samples through a 2-stage valid/ready pipeline.
- Truth tables are rewritten at run time through a drain-then-commit handshake, so no sample ever sees a half-updated table.
- Used as the generic function block in later lab datapaths, replacing fixed gate expressions.

---
 rtl/prog_bool_pkg.sv | 24 ++
 rtl/prog_bool_lut.sv | 36 +++
 rtl/prog_bool_unit.sv | 148 ++++++++++++++
 tb/tb_prog_bool_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_bool_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prog_bool_pkg
//  Description : Shared types and helpers for the programmable boolean unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package prog_bool_pkg;

    // Control states for the drain-then-commit table update
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int HITCNT_W = 16;

    // Truth-table width for an n_in-input function
    function automatic int tt_width(input int n_in);
        return 1 << n_in;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prog_bool_lut.sv
`default_nettype none
// ============================================================================
//  Module      : prog_bool_lut
//  Description : One channel of the boolean unit: truth-table register with a
//                write port and a combinational lookup mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_bool_lut import prog_bool_pkg::*; #(
    parameter int                   N_IN    = 3,
    parameter logic [(2**N_IN)-1:0] TT_INIT = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_we,
    input  logic [(2**N_IN)-1:0]   i_tt,
    input  logic [N_IN-1:0]        i_idx,
    output logic                   o_bit
);

    localparam int c_tt_w = tt_width(N_IN);

    logic [c_tt_w-1:0] r_tt;

    // Table register: reset image, replaced wholesale on a commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tt <= TT_INIT;
        end else if (i_we) begin
            r_tt <= i_tt;
        end
    end

    assign o_bit = r_tt[i_idx];

endmodule
`default_nettype wire

// File: rtl/prog_bool_unit.sv
`default_nettype none
// ============================================================================
//  Module      : prog_bool_unit
//  Description : N_CH programmable boolean functions of an N_IN-bit input,
//                evaluated in a 2-stage valid/ready pipeline. Tables are
//                rewritten only after the pipeline drains, so every sample
//                sees a consistent table set.
//  Options     : PROG_BOOL_HITCNT_EN adds per-channel 16-bit saturating
//                hit counters on output port hit_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_bool_unit import prog_bool_pkg::*; #(
    parameter int                   N_IN    = 3,
    parameter int                   N_CH    = 2,
    parameter logic [(2**N_IN)-1:0] TT_INIT = 8'h57
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [N_IN-1:0]                        in_vec,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [N_CH-1:0]                        out_vec,
    input  logic                                   cfg_we,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_ch,
    input  logic [(2**N_IN)-1:0]                   cfg_tt,
    output logic                                   cfg_ack
`ifdef PROG_BOOL_HITCNT_EN
    ,
    output logic [N_CH*HITCNT_W-1:0]               hit_cnt
`endif
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_s0_valid;
    logic              r_s1_valid;
    logic [N_IN-1:0]   r_s0_vec;
    logic [N_CH-1:0]   r_out_vec;
    logic [N_CH-1:0]   w_lut;
    logic              w_s1_adv;
    logic              w_s0_adv;
    logic              w_accept;
    logic              w_commit;

    // Each stage moves when it is empty or the stage after it moves
    assign w_s1_adv  = !r_s1_valid || out_ready;
    assign w_s0_adv  = !r_s0_valid || w_s1_adv;
    // A pending request closes the input immediately, even before DRAIN
    assign in_ready  = (r_state == RUN) && !cfg_we && w_s0_adv;
    assign w_accept  = in_valid && in_ready;
    assign w_commit  = (r_state == COMMIT);
    assign cfg_ack   = w_commit;
    assign out_valid = r_s1_valid;
    assign out_vec   = r_out_vec;

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: drain the pipeline, commit for one cycle, resume
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (cfg_we) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!cfg_we) begin
                    w_state_nxt = RUN;
                end else if (!r_s0_valid && !r_s1_valid) begin
                    w_state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // Two-stage pipeline: S0 holds the index, S1 holds the looked-up result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0_valid <= 1'b0;
            r_s0_vec   <= '0;
            r_s1_valid <= 1'b0;
            r_out_vec  <= '0;
        end else begin
            if (w_s0_adv) begin
                r_s0_valid <= w_accept;
                if (w_accept) r_s0_vec <= in_vec;
            end
            if (w_s1_adv) begin
                r_s1_valid <= r_s0_valid;
                if (r_s0_valid) r_out_vec <= w_lut;
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic w_we;

        // Out-of-range channel numbers match no channel, so nothing is written
        assign w_we = w_commit && (int'(cfg_ch) == k);

        prog_bool_lut #(
            .N_IN    (N_IN),
            .TT_INIT (TT_INIT)
        ) u_lut (
            .clk   (clk),
            .rst_n (rst_n),
            .i_we  (w_we),
            .i_tt  (cfg_tt),
            .i_idx (r_s0_vec),
            .o_bit (w_lut[k])
        );

`ifdef PROG_BOOL_HITCNT_EN
        logic [HITCNT_W-1:0] r_hit;

        // Saturating count of delivered results with this channel's bit set
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_hit <= '0;
            end else if (w_we) begin
                r_hit <= '0;
            end else if (out_valid && out_ready && r_out_vec[k] && (r_hit != '1)) begin
                r_hit <= r_hit + HITCNT_W'(1);
            end
        end

        assign hit_cnt[k*HITCNT_W +: HITCNT_W] = r_hit;
`else
        // No hit counters in this build
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_bool_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_bool_unit
//  Description : Directed self-checking bench for prog_bool_unit
//                (N_IN=3, TT_INIT=8'h57; main instance N_CH=2, a second
//                N_CH=3 instance reaches an out-of-range cfg_ch).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_bool_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [2:0] in_vec;
    logic [1:0] out_vec;
    logic       cfg_we, cfg_ack;
    logic       cfg_ch;
    logic [7:0] cfg_tt;

    logic       in_valid3, in_ready3, out_valid3, out_ready3;
    logic [2:0] in_vec3;
    logic [2:0] out_vec3;
    logic       cfg_we3, cfg_ack3;
    logic [1:0] cfg_ch3;
    logic [7:0] cfg_tt3;
`ifdef PROG_BOOL_HITCNT_EN
    logic [31:0] hit_cnt;
    logic [47:0] hit_cnt3;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prog_bool_unit #(.N_IN(3), .N_CH(2), .TT_INIT(8'h57)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_tt(cfg_tt), .cfg_ack(cfg_ack)
`ifdef PROG_BOOL_HITCNT_EN
        , .hit_cnt(hit_cnt)
`endif
    );

    prog_bool_unit #(.N_IN(3), .N_CH(3), .TT_INIT(8'h57)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_vec(in_vec3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_vec(out_vec3),
        .cfg_we(cfg_we3), .cfg_ch(cfg_ch3), .cfg_tt(cfg_tt3), .cfg_ack(cfg_ack3)
`ifdef PROG_BOOL_HITCNT_EN
        , .hit_cnt(hit_cnt3)
`endif
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Offer one sample, wait for its result; lat counts cycles from acceptance
    task automatic xfer(input logic [2:0] v, output logic [1:0] res, output int lat);
        int n;
        n = 0;
        in_valid  = 1'b1;
        in_vec    = v;
        out_ready = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 10) begin
            step();
            @(negedge clk);
            n++;
        end
        step();
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 10) begin
            step();
            @(negedge clk);
            lat++;
        end
        res = out_vec;
        if (!out_valid) lat = -1;
        step();
    endtask

    // Raise a table write and hold it until acknowledged; lat = cycles to ack
    task automatic cfg_write(input logic ch, input logic [7:0] tt, output int lat);
        cfg_we = 1'b1;
        cfg_ch = ch;
        cfg_tt = tt;
        lat = 0;
        @(negedge clk);
        while (!cfg_ack && lat < 20) begin
            step();
            @(negedge clk);
            lat++;
        end
        if (!cfg_ack) lat = -1;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_vec !== 2'b00) begin failures++; $display("FAIL reset_out_vec: got %b want 00", out_vec); end
        checks++; if (cfg_ack !== 1'b0) begin failures++; $display("FAIL reset_cfg_ack: got %b want 0", cfg_ack); end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        step();
    endtask

    task automatic test_basic;
        logic [2:0] vecs [4] = '{3'd0, 3'd3, 3'd6, 3'd7};
        logic [1:0] exps [4] = '{2'b11, 2'b00, 2'b11, 2'b00};
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_valid = (c < 4);
            in_vec   = (c < 4) ? vecs[c] : 3'd0;
            @(negedge clk);
            if (c < 4) begin
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_in_ready c%0d: got %b want 1", c, in_ready); end
            end
            if (c >= 2) begin
                checks++;
                if ({out_valid, out_vec} !== {1'b1, exps[c-2]}) begin
                    failures++; $display("FAIL basic_out c%0d: got v=%b d=%b want v=1 d=%b", c, out_valid, out_vec, exps[c-2]);
                end
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [1:0] bp_exp [8] = '{2'b11, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00};
        logic [1:0] q [$];
        logic [1:0] held;
        logic [1:0] want;
        bit         stalled;
        int         sent, got, cyc, first_low;
        sent = 0; got = 0; cyc = 0; first_low = -1; stalled = 1'b0; held = 2'b00;
        while (got < 8 && cyc < 40) begin
            in_valid  = (sent < 8);
            in_vec    = 3'(sent);
            out_ready = (cyc >= 4);
            @(negedge clk);
            if (stalled) begin
                checks++;
                if ({out_valid, out_vec} !== {1'b1, held}) begin
                    failures++; $display("FAIL bp_frozen c%0d: got v=%b d=%b want v=1 d=%b", cyc, out_valid, out_vec, held);
                end
            end
            if (in_valid && !in_ready && first_low < 0) first_low = sent;
            if (in_valid && in_ready) begin
                q.push_back(bp_exp[sent]);
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++; $display("FAIL bp_extra: got unexpected result %b want none", out_vec);
                end else begin
                    want = q.pop_front();
                    if (out_vec !== want) begin failures++; $display("FAIL bp_data #%0d: got %b want %b", got, out_vec, want); end
                end
                got++;
            end
            stalled = out_valid && !out_ready;
            held    = out_vec;
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++; if (got != 8) begin failures++; $display("FAIL bp_count: got %0d want 8", got); end
        checks++; if (q.size() != 0) begin failures++; $display("FAIL bp_left: got %0d want 0", q.size()); end
        checks++; if (first_low != 2) begin failures++; $display("FAIL bp_ready_drop: got %0d want 2", first_low); end
    endtask

    task automatic test_cfg_midstream;
        int         ack_cyc, nout, lat;
        logic [1:0] res;
        ack_cyc = -1; nout = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && ack_cyc < 0; c++) begin
            in_valid = (c <= 2);
            in_vec   = (c < 2) ? 3'd3 : 3'd5;
            cfg_we   = (c >= 2);
            cfg_ch   = 1'b1;
            cfg_tt   = 8'hFF;
            @(negedge clk);
            if (c >= 2) begin
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL cfg_in_ready c%0d: got %b want 0", c, in_ready); end
            end
            if (out_valid) begin
                nout++;
                checks++; if (out_vec !== 2'b00) begin failures++; $display("FAIL cfg_old_table: got %b want 00", out_vec); end
            end
            if (cfg_ack) ack_cyc = c;
            step();
        end
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        checks++; if (ack_cyc != 5) begin failures++; $display("FAIL cfg_ack_cycle: got %0d want 5", ack_cyc); end
        checks++; if (nout != 2) begin failures++; $display("FAIL cfg_inflight: got %0d want 2", nout); end
        @(negedge clk);
        checks++; if ({cfg_ack, in_ready} !== 2'b01) begin failures++; $display("FAIL cfg_ack_pulse: got ack=%b rdy=%b want ack=0 rdy=1", cfg_ack, in_ready); end
        step();
        xfer(3'd3, res, lat);
        checks++; if (res !== 2'b10) begin failures++; $display("FAIL cfg_new_table: got %b want 10", res); end
        checks++; if (lat != 2) begin failures++; $display("FAIL cfg_latency: got %0d want 2", lat); end
    endtask

    task automatic test_cfg_invalid;
        logic [2:0] exps [2] = '{3'b111, 3'b000};
        int ack_cyc;
        ack_cyc = -1;
        cfg_we3 = 1'b1; cfg_ch3 = 2'd3; cfg_tt3 = 8'hFF;
        for (int c = 0; c < 10 && ack_cyc < 0; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checks++; if (in_ready3 !== 1'b0) begin failures++; $display("FAIL inv_in_ready: got %b want 0", in_ready3); end
            end
            if (cfg_ack3) ack_cyc = c;
            step();
        end
        cfg_we3 = 1'b0;
        checks++; if (ack_cyc != 2) begin failures++; $display("FAIL inv_ack_cycle: got %0d want 2", ack_cyc); end
        for (int c = 0; c < 4; c++) begin
            in_valid3 = (c < 2);
            in_vec3   = (c == 0) ? 3'd1 : 3'd3;
            @(negedge clk);
            if (c >= 2) begin
                checks++;
                if ({out_valid3, out_vec3} !== {1'b1, exps[c-2]}) begin
                    failures++; $display("FAIL inv_tables c%0d: got v=%b d=%b want v=1 d=%b", c, out_valid3, out_vec3, exps[c-2]);
                end
            end
            step();
        end
        in_valid3 = 1'b0;
    endtask

    task automatic test_reset_drain;
        int         lat;
        logic [1:0] res;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_vec    = 3'd0;
        step();
        step();
        in_valid = 1'b0;
        cfg_we   = 1'b1; cfg_ch = 1'b0; cfg_tt = 8'h00;
        step();
        @(negedge clk);
        checks++; if ({out_valid, cfg_ack} !== 2'b10) begin failures++; $display("FAIL rd_pre: got v=%b ack=%b want v=1 ack=0", out_valid, cfg_ack); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rd_async_clear: got %b want 0", out_valid); end
        cfg_we = 1'b0;
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if ({cfg_ack, out_valid} !== 2'b00) begin failures++; $display("FAIL rd_quiet c%0d: got ack=%b v=%b want 0 0", c, cfg_ack, out_valid); end
            step();
        end
        xfer(3'd3, res, lat);
        checks++; if (res !== 2'b00) begin failures++; $display("FAIL rd_tables: got %b want 00", res); end
    endtask

    task automatic test_back_to_back;
        int         lat1, lat2, lat;
        logic [1:0] res;
        cfg_write(1'b0, 8'h0F, lat1);
        cfg_write(1'b1, 8'hF0, lat2);
        checks++; if (lat1 != 2) begin failures++; $display("FAIL b2b_lat1: got %0d want 2", lat1); end
        checks++; if (lat2 != 2) begin failures++; $display("FAIL b2b_lat2: got %0d want 2", lat2); end
        xfer(3'd0, res, lat);
        checks++; if (res !== 2'b01) begin failures++; $display("FAIL b2b_vec0: got %b want 01", res); end
        xfer(3'd7, res, lat);
        checks++; if (res !== 2'b10) begin failures++; $display("FAIL b2b_vec7: got %b want 10", res); end
    endtask

`ifdef PROG_BOOL_HITCNT_EN
    task automatic test_hitcnt;
        int         lat;
        logic [1:0] res;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        cfg_write(1'b1, 8'h00, lat);
        for (int i = 0; i < 5; i++) begin
            xfer(3'd0, res, lat);
            checks++; if (res !== 2'b01) begin failures++; $display("FAIL hit_data %0d: got %b want 01", i, res); end
        end
        checks++; if (hit_cnt !== {16'd0, 16'd5}) begin failures++; $display("FAIL hit_five: got %h want 00000005", hit_cnt); end
        cfg_write(1'b1, 8'hFF, lat);
        xfer(3'd0, res, lat);
        xfer(3'd0, res, lat);
        checks++; if (hit_cnt !== {16'd2, 16'd7}) begin failures++; $display("FAIL hit_both: got %h want 00020007", hit_cnt); end
        cfg_write(1'b0, 8'h57, lat);
        checks++; if (hit_cnt !== {16'd2, 16'd0}) begin failures++; $display("FAIL hit_clear: got %h want 00020000", hit_cnt); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_vec = 3'd0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_ch = 1'b0; cfg_tt = 8'h00;
        in_valid3 = 1'b0; in_vec3 = 3'd0; out_ready3 = 1'b1;
        cfg_we3 = 1'b0; cfg_ch3 = 2'd0; cfg_tt3 = 8'h00;
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_cfg_midstream();
        test_cfg_invalid();
        test_reset_drain();
        test_back_to_back();
`ifdef PROG_BOOL_HITCNT_EN
        test_hitcnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
